// File: rtl/mesi_snoop_responder.sv
// MESI snoop responder: answers bus snoops against a direct-mapped tag/state store, latency 2 cycles (accept->rsp), +wb stall.
// One snoop in flight (snp_ready only in IDLE); wb_valid held until wb_ready. MESI_SNOOP_ERR_EN enables INVALIDATE-on-E/M proto_err.
module mesi_snoop_responder #(
   parameter int LINES    = 16,
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_addr,
   input  logic [1:0]        upd_state,
   input  logic              snp_valid,
   output logic              snp_ready,
   input  logic [2:0]        snp_op,
   input  logic [ADDR_W-1:0] snp_addr,
   output logic              rsp_valid,
   output logic [1:0]        rsp_result,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [ADDR_W-1:0] wb_addr,
   output logic              proto_err
);

   localparam int IDX_W  = $clog2(LINES);
   localparam int LINE_W = ADDR_W - OFFSET_W;
   localparam int TAG_W  = ADDR_W - OFFSET_W - IDX_W;

   localparam logic [1:0] LS_I = 2'b00;
   localparam logic [1:0] LS_S = 2'b01;
   localparam logic [1:0] LS_E = 2'b10;
   localparam logic [1:0] LS_M = 2'b11;

   localparam logic [1:0] RES_NOHIT = 2'b00;
   localparam logic [1:0] RES_HIT   = 2'b01;
   localparam logic [1:0] RES_HITM  = 2'b10;

   localparam logic [2:0] OP_READ  = 3'd1;
   localparam logic [2:0] OP_WRITE = 3'd2;
   localparam logic [2:0] OP_RWIM  = 3'd3;
   localparam logic [2:0] OP_INVAL = 3'd4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      WB     = 2'd2,
      RESP   = 2'd3
   } fsm_t;

   fsm_t state, state_nxt;

   logic [TAG_W-1:0] tag_q [LINES];
   logic [1:0]       st_q  [LINES];

   logic [2:0]        op_q;
   logic [LINE_W-1:0] line_q;
   logic [IDX_W-1:0]  cap_idx;
   logic [TAG_W-1:0]  cap_tag;

   logic [IDX_W-1:0]  upd_idx;
   logic [TAG_W-1:0]  upd_tag;

   logic [1:0]        new_st_q;
   logic              commit_q;
   logic [1:0]        res_q;
   logic [1:0]        rsp_result_q;
   logic              wb_valid_q;
   logic [ADDR_W-1:0] wb_addr_q;

   logic [1:0]        cur_st;
   logic [TAG_W-1:0]  cur_tag;
   logic              lk_hit;
   logic [1:0]        lk_result;
   logic [1:0]        lk_new;
   logic              lk_commit;
   logic              lk_wb;

`ifdef MESI_SNOOP_ERR_EN
   logic lk_err;
   logic err_q;
`endif

   // Offset bits never reach the store; folded here so they are visibly consumed.
   logic unused_offset_bits;
   assign unused_offset_bits = ^{snp_addr[OFFSET_W-1:0], upd_addr[OFFSET_W-1:0]};

   assign cap_idx = line_q[IDX_W-1:0];
   assign cap_tag = line_q[LINE_W-1 -: TAG_W];
   assign upd_idx = upd_addr[OFFSET_W +: IDX_W];
   assign upd_tag = upd_addr[ADDR_W-1 -: TAG_W];

   assign cur_st  = st_q[cap_idx];
   assign cur_tag = tag_q[cap_idx];
   assign lk_hit  = (cur_st != LS_I) && (cur_tag == cap_tag);

   always_comb begin
      lk_result = RES_NOHIT;
      lk_new    = cur_st;
      lk_commit = 1'b0;
      lk_wb     = 1'b0;
`ifdef MESI_SNOOP_ERR_EN
      lk_err    = 1'b0;
`endif
      if (lk_hit) begin
         case (op_q)
            OP_READ: begin
               lk_result = (cur_st == LS_M) ? RES_HITM : RES_HIT;
               lk_new    = LS_S;
               lk_commit = 1'b1;
               lk_wb     = (cur_st == LS_M);
            end
            OP_RWIM: begin
               lk_result = (cur_st == LS_M) ? RES_HITM : RES_HIT;
               lk_new    = LS_I;
               lk_commit = 1'b1;
               lk_wb     = (cur_st == LS_M);
            end
            OP_INVAL: begin
               lk_result = RES_HIT;
`ifdef MESI_SNOOP_ERR_EN
               // Another cache invalidating our exclusive copy is illegal: flag it, keep the line.
               if (cur_st == LS_S) begin
                  lk_new    = LS_I;
                  lk_commit = 1'b1;
               end else begin
                  lk_err = 1'b1;
               end
`else
               lk_new    = LS_I;
               lk_commit = 1'b1;
`endif
            end
            OP_WRITE: begin
               lk_result = RES_NOHIT;
            end
            default: begin
               lk_result = RES_NOHIT;
            end
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (snp_valid) state_nxt = LOOKUP;
         LOOKUP:  state_nxt = lk_wb ? WB : RESP;
         WB:      if (wb_ready) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q         <= '0;
         line_q       <= '0;
         new_st_q     <= LS_I;
         commit_q     <= 1'b0;
         res_q        <= RES_NOHIT;
         rsp_result_q <= RES_NOHIT;
         wb_valid_q   <= 1'b0;
         wb_addr_q    <= '0;
`ifdef MESI_SNOOP_ERR_EN
         err_q        <= 1'b0;
`endif
      end else begin
         if (state == IDLE && snp_valid) begin
            op_q   <= snp_op;
            line_q <= snp_addr[ADDR_W-1:OFFSET_W];
         end
         if (state == LOOKUP) begin
            new_st_q <= lk_new;
            commit_q <= lk_commit;
            res_q    <= lk_result;
`ifdef MESI_SNOOP_ERR_EN
            err_q    <= lk_err;
`endif
            if (lk_wb) begin
               wb_valid_q <= 1'b1;
               wb_addr_q  <= {line_q, {OFFSET_W{1'b0}}};
            end else begin
               rsp_result_q <= lk_result;
            end
         end
         // Result is published only when the response actually goes out.
         if (state == WB && wb_ready) begin
            wb_valid_q   <= 1'b0;
            rsp_result_q <= res_q;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LINES; i++) begin
            tag_q[i] <= '0;
            st_q[i]  <= LS_I;
         end
      end else begin
         if (state == RESP && commit_q && !(upd_valid && upd_idx == cap_idx))
            st_q[cap_idx] <= new_st_q;
         if (upd_valid) begin
            tag_q[upd_idx] <= upd_tag;
            st_q[upd_idx]  <= upd_state;
         end
      end
   end

   assign snp_ready  = (state == IDLE);
   assign rsp_valid  = (state == RESP);
   assign rsp_result = rsp_result_q;
   assign wb_valid   = wb_valid_q;
   assign wb_addr    = wb_addr_q;

`ifdef MESI_SNOOP_ERR_EN
   assign proto_err = (state == RESP) && err_q;
`else
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mesi_snoop_responder.sv
// Directed bench for mesi_snoop_responder: hand-computed snoop results, writeback handshake, collisions and reset abort.
module tb_mesi_snoop_responder;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_READ  = 3'd1;
   localparam logic [2:0] OP_WRITE = 3'd2;
   localparam logic [2:0] OP_RWIM  = 3'd3;
   localparam logic [2:0] OP_INVAL = 3'd4;

   localparam logic [1:0] NOHIT = 2'b00;
   localparam logic [1:0] HIT   = 2'b01;
   localparam logic [1:0] HITM  = 2'b10;

   localparam logic [1:0] ST_S = 2'b01;
   localparam logic [1:0] ST_E = 2'b10;
   localparam logic [1:0] ST_M = 2'b11;

   logic        clk = 1'b0;
   logic        reset;
   logic        upd_valid;
   logic [31:0] upd_addr;
   logic [1:0]  upd_state;
   logic        snp_valid;
   logic        snp_ready;
   logic [2:0]  snp_op;
   logic [31:0] snp_addr;
   logic        rsp_valid;
   logic [1:0]  rsp_result;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_addr;
   logic        proto_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mesi_snoop_responder #(.LINES(16), .ADDR_W(32), .OFFSET_W(6)) dut (
      .clk       (clk),
      .reset     (reset),
      .upd_valid (upd_valid),
      .upd_addr  (upd_addr),
      .upd_state (upd_state),
      .snp_valid (snp_valid),
      .snp_ready (snp_ready),
      .snp_op    (snp_op),
      .snp_addr  (snp_addr),
      .rsp_valid (rsp_valid),
      .rsp_result(rsp_result),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_addr   (wb_addr),
      .proto_err (proto_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic install(input logic [31:0] addr, input logic [1:0] st);
      upd_valid = 1'b1;
      upd_addr  = addr;
      upd_state = st;
      tick();
      upd_valid = 1'b0;
   endtask

   // Full snoop without a writeback: accept, LOOKUP, RESP, back to IDLE.
   task automatic snoop(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [1:0] exp_res, input logic exp_err);
      check({tag, ":ready"}, snp_ready, 1);
      snp_valid = 1'b1;
      snp_op    = op;
      snp_addr  = addr;
      tick();
      snp_valid = 1'b0;
      check({tag, ":lookup_rsp"}, rsp_valid, 0);
      check({tag, ":lookup_ready"}, snp_ready, 0);
      tick();
      check({tag, ":rsp_valid"}, rsp_valid, 1);
      check({tag, ":result"}, rsp_result, exp_res);
      check({tag, ":no_wb"}, wb_valid, 0);
      check({tag, ":proto_err"}, proto_err, exp_err);
      tick();
      check({tag, ":rsp_drop"}, rsp_valid, 0);
      check({tag, ":err_drop"}, proto_err, 0);
      check({tag, ":result_held"}, rsp_result, exp_res);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b1;
      upd_valid = 1'b0;
      upd_addr  = '0;
      upd_state = '0;
      snp_valid = 1'b0;
      snp_op    = '0;
      snp_addr  = '0;
      wb_ready  = 1'b0;
      #1;
      check("rst:snp_ready", snp_ready, 1);
      check("rst:rsp_valid", rsp_valid, 0);
      check("rst:rsp_result", rsp_result, 0);
      check("rst:wb_valid", wb_valid, 0);
      check("rst:wb_addr", wb_addr, 0);
      check("rst:proto_err", proto_err, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Empty store.
      snoop("read_empty", OP_READ, 32'h0000_1000, NOHIT, 1'b0);

      // Modified line: writeback stalled for three cycles.
      install(32'h0000_1040, ST_M);
      snp_valid = 1'b1;
      snp_op    = OP_READ;
      snp_addr  = 32'h0000_1040;
      tick();
      snp_valid = 1'b0;
      check("wbm:lookup_wb", wb_valid, 0);
      tick();
      check("wbm:wb_valid", wb_valid, 1);
      check("wbm:wb_addr", wb_addr, 32'h0000_1040);
      check("wbm:no_rsp", rsp_valid, 0);
      tick();
      check("wbm:hold1", wb_valid, 1);
      check("wbm:hold1_addr", wb_addr, 32'h0000_1040);
      tick();
      check("wbm:hold2", wb_valid, 1);
      check("wbm:hold2_rsp", rsp_valid, 0);
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      check("wbm:rsp_valid", rsp_valid, 1);
      check("wbm:result", rsp_result, HITM);
      check("wbm:wb_done", wb_valid, 0);
      tick();
      check("wbm:idle", snp_ready, 1);
      snoop("wbm_resnoop", OP_READ, 32'h0000_1040, HIT, 1'b0);

      // Exclusive line taken by RWIM.
      install(32'h0000_2080, ST_E);
      snoop("rwim_e", OP_RWIM, 32'h0000_2080, HIT, 1'b0);
      snoop("rwim_after", OP_READ, 32'h0000_2080, NOHIT, 1'b0);

      // Same index, different tag.
      install(32'h0000_14C0, ST_S);
      snoop("inv_tagB", OP_INVAL, 32'h0000_18C0, NOHIT, 1'b0);
      snoop("inv_tagA_kept", OP_READ, 32'h0000_14C0, HIT, 1'b0);
      snoop("inv_tagA", OP_INVAL, 32'h0000_14C0, HIT, 1'b0);
      snoop("inv_tagA_gone", OP_READ, 32'h0000_14C0, NOHIT, 1'b0);

      // INVALIDATE against an Exclusive line.
      install(32'h0000_3100, ST_E);
`ifdef MESI_SNOOP_ERR_EN
      snoop("inv_e", OP_INVAL, 32'h0000_3100, HIT, 1'b1);
      snoop("inv_e_kept", OP_READ, 32'h0000_3100, HIT, 1'b0);
`else
      snoop("inv_e", OP_INVAL, 32'h0000_3100, HIT, 1'b0);
      snoop("inv_e_gone", OP_READ, 32'h0000_3100, NOHIT, 1'b0);
`endif

      // WRITE and NOP opcodes leave the line alone.
      install(32'h0000_5000, ST_S);
      snoop("write_s", OP_WRITE, 32'h0000_5000, NOHIT, 1'b0);
      snoop("nop0_s", OP_NOP, 32'h0000_5000, NOHIT, 1'b0);
      snoop("nop7_s", 3'd7, 32'h0000_5000, NOHIT, 1'b0);
      snoop("s_kept", OP_READ, 32'h0000_5000, HIT, 1'b0);

      // Update collides with the commit edge: the update wins.
      install(32'h0000_1040, ST_M);
      snp_valid = 1'b1;
      snp_op    = OP_READ;
      snp_addr  = 32'h0000_1040;
      tick();
      snp_valid = 1'b0;
      tick();
      check("coll:wb_valid", wb_valid, 1);
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      check("coll:rsp_valid", rsp_valid, 1);
      check("coll:result", rsp_result, HITM);
      upd_valid = 1'b1;
      upd_addr  = 32'h0000_1040;
      upd_state = ST_E;
      tick();
      upd_valid = 1'b0;
      snoop("coll_final_e", OP_READ, 32'h0000_1040, HIT, 1'b0);

      // Reset while a writeback is pending.
      install(32'h0000_1040, ST_M);
      install(32'h0000_2080, ST_S);
      snp_valid = 1'b1;
      snp_op    = OP_READ;
      snp_addr  = 32'h0000_1040;
      tick();
      snp_valid = 1'b0;
      tick();
      check("rstwb:wb_valid_pre", wb_valid, 1);
      reset = 1'b1;
      #1;
      check("rstwb:wb_valid", wb_valid, 0);
      check("rstwb:wb_addr", wb_addr, 0);
      check("rstwb:rsp_valid", rsp_valid, 0);
      check("rstwb:snp_ready", snp_ready, 1);
      tick();
      reset = 1'b0;
      tick();
      snoop("rstwb_m_gone", OP_READ, 32'h0000_1040, NOHIT, 1'b0);
      snoop("rstwb_s_gone", OP_READ, 32'h0000_2080, NOHIT, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mesi_snoop_responder.md
# mesi_snoop_responder

Bus-side counterpart of the per-line MESI state machine: it answers snooped bus operations issued by other caches against a small direct-mapped tag/state store. It returns the snoop result and demotes or invalidates local line state, and requests a writeback when a Modified line is hit. It sits between the shared-bus model and the local cache controller, which installs and updates line states through the update port.

## Interface

- LINES, 16, number of tracked lines (power of two, ≥2); IDX_W = $clog2(LINES)
- ADDR_W, 32, bus address width
- OFFSET_W, 6, line offset bits; TAG_W = ADDR_W − OFFSET_W − IDX_W
- clk  input  1  clock; all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- upd_valid  input  1  local controller writes a line's tag and state this cycle
- upd_addr  input  ADDR_W  address of the line being installed or updated
- upd_state  input  2  new state: I=00, S=01, E=10, M=11
- snp_valid  input  1  snoop request valid
- snp_ready  output  1  responder can accept a snoop (high only in IDLE)
- snp_op  input  3  1=READ, 2=WRITE, 3=RWIM, 4=INVALIDATE; other values are NOP
- snp_addr  input  ADDR_W  snooped address
- rsp_valid  output  1  one-cycle pulse; result is valid
- rsp_result  output  2  NOHIT=00, HIT=01, HITM=10
- wb_valid  output  1  writeback request, held until accepted
- wb_ready  input  1  bus accepts the writeback
- wb_addr  output  ADDR_W  line-aligned writeback address (offset bits zero)
- proto_err  output  1  one-cycle protocol-violation pulse (see Configuration)

## Operation

- Store: LINES entries of {tag, state}. index = addr[OFFSET_W +: IDX_W]; tag = addr[ADDR_W-1 -: TAG_W]. A lookup hits when the tags match and state ≠ I.
- FSM states and transitions:
  - IDLE → LOOKUP on snp_valid & snp_ready. Op and address are captured.
  - LOOKUP → WB when the lookup hits a line in M and the op is READ or RWIM. Otherwise LOOKUP → RESP.
  - WB → RESP on wb_valid & wb_ready.
  - RESP → IDLE.
- Snoop rules (current → next, result):
  - READ: M→S HITM with writeback; E→S HIT; S→S HIT; miss NOHIT.
  - RWIM: M→I HITM with writeback; E→I HIT; S→I HIT; miss NOHIT.
  - INVALIDATE: S→I HIT; miss NOHIT. E or M is a protocol violation: state is unchanged, result HIT, proto_err fires.
  - WRITE and NOP: no state change, NOHIT.
- The state change is committed on the clock edge that ends RESP.
- Update port: honoured in every FSM state. It writes both tag and state (upd_state=I invalidates the line).
- Collision: if upd_valid targets the same index on the edge that ends RESP, the update wins and the snoop commit is dropped.
- An update to the captured index during LOOKUP or WB does not alter the already-computed result.

## Timing

- Reset values:
  - FSM is IDLE and all entries are I with tag 0.
  - snp_ready=1. rsp_valid, rsp_result, wb_valid, wb_addr and proto_err are all 0.
- snp_ready is combinational from the FSM state (IDLE only).
- No writeback: the request is accepted on edge T. LOOKUP runs in cycle T+1 and rsp_valid is high in cycle T+2. Next accept is possible at edge T+3.
- Writeback: wb_valid and wb_addr are registered and rise in cycle T+2. They stay stable until the edge where wb_ready=1. rsp_valid is high the following cycle.
- rsp_result holds its value until the next response. proto_err pulses in the same cycle as rsp_valid.
- Back-to-back snoops: throughput is at most one per 3 cycles.
- Reset asserted mid-operation aborts the operation immediately. wb_valid and rsp_valid drop, and no commit occurs.

## Configuration

- MESI_SNOOP_ERR_EN defined: the INVALIDATE-on-E/M check is active and proto_err pulses as described.
- MESI_SNOOP_ERR_EN undefined: proto_err is tied 0. INVALIDATE on E or M then behaves like RWIM without a writeback: state→I, result HIT.

## Test plan

- Reset, then READ at 0x0000_1000 with an empty store → rsp_valid at T+2, NOHIT, wb_valid never asserted.
- Install 0x0000_1040 as M, then READ → wb_valid=1, wb_addr=0x0000_1040 at T+2. Hold wb_ready=0 for 3 cycles, then 1 → rsp HITM the next cycle. A re-snoop shows state S (READ → HIT).
- Install 0x0000_2080 as E, then RWIM → HIT, no writeback; a following READ → NOHIT.
- Install S at index 3 with tag A, then INVALIDATE to tag B at the same index → NOHIT and line unchanged. INVALIDATE to tag A → HIT, then I.
- With the macro defined: install E, then INVALIDATE → HIT, proto_err=1 for one cycle, state still E. With it undefined: proto_err=0 and state I.
- READ to an M line with upd_valid (same index, upd_state=E) on the RESP edge → final state E. Separately, assert reset while in WB → wb_valid=0 immediately and all lines I.
